// File: rtl/binary_target_locator.sv
// Per-frame foreground measurement on a 1-bit pixel stream: bounding box, pixel count
// and box centre, latched at vsync fall and held until the next frame completes.
module binary_target_locator #(
  parameter logic [9:0]  IMG_HDISP  = 10'd320,
  parameter logic [9:0]  IMG_VDISP  = 10'd240,
  parameter logic [19:0] MIN_PIXELS = 20'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_Bit,
  output logic        frame_done,
  output logic        target_valid,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic [9:0]  x_center,
  output logic [9:0]  y_center,
  output logic [19:0] pixel_count
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_vsync_d;
  logic        r_href_d;
  logic        r_armed;
  logic [9:0]  r_x_cnt;
  logic [9:0]  r_y_cnt;
  logic [9:0]  r_xmin;
  logic [9:0]  r_xmax;
  logic [9:0]  r_ymin;
  logic [9:0]  r_ymax;
  logic [19:0] r_count;

  logic        w_vsync_rise;
  logic        w_vsync_fall;
  logic        w_href_fall;
  logic        w_strobe;
  logic        w_in_window;
  logic        w_start;
  logic        w_latch;
  logic [10:0] w_x_sum;
  logic [10:0] w_y_sum;

  // r_armed blocks a rise right after reset while vsync is still high, so a frame
  // interrupted by reset can never be measured or reported.
  assign w_vsync_rise = per_frame_vsync & ~r_vsync_d & r_armed;
  assign w_vsync_fall = ~per_frame_vsync & r_vsync_d;
  assign w_href_fall  = ~per_frame_href & r_href_d;
  assign w_strobe     = per_frame_vsync & per_frame_href & per_frame_clken;
  assign w_in_window  = (r_x_cnt < IMG_HDISP) && (r_y_cnt < IMG_VDISP);
  assign w_x_sum      = {1'b0, r_xmin} + {1'b0, r_xmax};
  assign w_y_sum      = {1'b0, r_ymin} + {1'b0, r_ymax};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_vsync_d <= per_frame_vsync;
      r_href_d  <= per_frame_href;
      if (!per_frame_vsync) r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vsync_rise) begin
          w_next  = S_ACCUM;
          w_start = 1'b1;
        end
      end
      S_ACCUM: begin
        if (w_vsync_fall) begin
          w_next  = S_IDLE;
          w_latch = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
      r_xmin  <= 10'h3FF;
      r_xmax  <= '0;
      r_ymin  <= 10'h3FF;
      r_ymax  <= '0;
      r_count <= '0;
    end else if (r_state == S_ACCUM && !w_vsync_fall) begin
      if (w_strobe) begin
        if (r_x_cnt != 10'h3FF) r_x_cnt <= r_x_cnt + 10'd1;
        if (w_in_window && per_img_Bit) begin
          if (r_count != 20'hFFFFF) r_count <= r_count + 20'd1;
          if (r_x_cnt < r_xmin) r_xmin <= r_x_cnt;
          if (r_x_cnt > r_xmax) r_xmax <= r_x_cnt;
          if (r_y_cnt < r_ymin) r_ymin <= r_y_cnt;
          if (r_y_cnt > r_ymax) r_ymax <= r_y_cnt;
        end
      end else if (w_href_fall) begin
        r_x_cnt <= '0;
        if (r_y_cnt != 10'h3FF) r_y_cnt <= r_y_cnt + 10'd1;
      end
    end
  end

  // Results are only published here; accumulators never reach the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done   <= 1'b0;
      target_valid <= 1'b0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      x_center     <= '0;
      y_center     <= '0;
      pixel_count  <= '0;
    end else begin
      frame_done <= w_latch;
      if (w_latch) begin
        pixel_count <= r_count;
        if (r_count >= MIN_PIXELS) begin
          target_valid <= 1'b1;
          x_min        <= r_xmin;
          x_max        <= r_xmax;
          y_min        <= r_ymin;
          y_max        <= r_ymax;
          x_center     <= w_x_sum[10:1];
          y_center     <= w_y_sum[10:1];
        end else begin
          target_valid <= 1'b0;
          x_min        <= '0;
          x_max        <= '0;
          y_min        <= '0;
          y_max        <= '0;
          x_center     <= '0;
          y_center     <= '0;
        end
      end
    end
  end

endmodule
